bcd_adder: RTL and testbench

BCD_ADDER -- requirements
Module: bcd_adder

---
 rtl/bcd_adder_pkg.sv | 14 +
 rtl/bcd_full_adder.sv | 13 +
 rtl/bcd_adder.sv | 66 ++++++
 tb/tb_bcd_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_adder_pkg.sv
// Shared constants and helpers for the single-digit BCD adder.
// Digit width, largest legal BCD digit and the decimal correction offset.
package bcd_adder_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    // Binary sum above 9: either the adder overflowed or the 4-bit pattern is 10..15.
    function automatic logic needs_corr(input logic carry_out, input logic [DIGIT_W-1:0] sum);
        return carry_out | (sum[3] & (sum[2] | sum[1]));
    endfunction

endpackage

// File: rtl/bcd_full_adder.sv
// One-bit full adder; four of these chained form the binary stage of bcd_adder.
module bcd_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bcd_adder.sv
// Registered single-digit BCD adder: ripple-carry binary sum followed by +6 correction.
// Define BCD_ADDER_INVALID_FLAG_EN to add the registered 'err' flag for non-BCD inputs.
module bcd_adder
    import bcd_adder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic [DIGIT_W:1]   c,
    output logic               cout,
    output logic [DIGIT_W-1:0] bcd
`ifdef BCD_ADDER_INVALID_FLAG_EN
    ,
    output logic               err
`endif
);

    logic [DIGIT_W:0]   carry;
    logic [DIGIT_W-1:0] sum;
    logic               k;
    logic [DIGIT_W-1:0] bcd_next;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
        bcd_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Inputs 10..15 are not rejected; they go through the same correction path.
    assign k        = needs_corr(carry[DIGIT_W], sum);
    assign bcd_next = k ? sum + DIGIT_W'(BCD_CORR) : sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            c    <= '0;
            cout <= 1'b0;
            bcd  <= '0;
        end else begin
            s    <= sum;
            c    <= carry[DIGIT_W:1];
            cout <= k;
            bcd  <= bcd_next;
        end
    end

`ifdef BCD_ADDER_INVALID_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (a > DIGIT_W'(BCD_MAX)) | (b > DIGIT_W'(BCD_MAX));
        end
    end
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Scoreboard bench for bcd_adder: directed hand-checked vectors, reset checks, full 512-case sweep.
// Compiles with or without BCD_ADDER_INVALID_FLAG_EN.
module tb_bcd_adder;

    typedef struct packed {
        logic [3:0] s;
        logic [4:1] c;
        logic       cout;
        logic [3:0] bcd;
        logic       err;
    } result_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        result_t    exp;
    } vector_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic [4:1] c;
    logic       cout;
    logic [3:0] bcd;
    logic       err_act;

    int vectors_applied = 0;
    int miscompares     = 0;

    result_t sb[$];

    bcd_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .c     (c),
        .cout  (cout),
        .bcd   (bcd)
`ifdef BCD_ADDER_INVALID_FLAG_EN
        ,
        .err   (err_act)
`endif
    );

`ifndef BCD_ADDER_INVALID_FLAG_EN
    assign err_act = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: carries from truncated partial sums, not a bitwise ripple.
    function automatic result_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mcin);
        result_t r;
        int      total;
        total = int'(ma) + int'(mb) + int'(mcin);
        r.s   = 4'(total % 16);
        for (int i = 1; i <= 4; i++) begin
            r.c[i] = ((int'(ma) % (1 << i)) + (int'(mb) % (1 << i)) + int'(mcin)) >= (1 << i);
        end
        r.cout = total > 9;
        r.bcd  = r.cout ? 4'((total + 6) % 16) : 4'(total % 16);
        r.err  = (ma > 4'd9) || (mb > 4'd9);
        return r;
    endfunction

    function automatic result_t sample();
        result_t r;
        r.s    = s;
        r.c    = c;
        r.cout = cout;
        r.bcd  = bcd;
        r.err  = err_act;
        return r;
    endfunction

    task automatic checkOutput(input string name, input result_t exp);
        result_t act;
        act = sample();
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got s=%h c=%b cout=%b bcd=%h err=%b, expected s=%h c=%b cout=%b bcd=%h err=%b",
                     name, act.s, act.c, act.cout, act.bcd, act.err,
                     exp.s, exp.c, exp.cout, exp.bcd, exp.err);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb, input logic tcin,
                                 input result_t exp);
        @(negedge clk);
        a   = ta;
        b   = tb;
        cin = tcin;
`ifndef BCD_ADDER_INVALID_FLAG_EN
        exp.err = 1'b0;
`endif
        sb.push_back(exp);
    endtask

    // Monitor: outputs are valid every cycle, so each pending expectation is checked just after its edge.
    initial begin
        result_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("scoreboard", e);
            end
        end
    end

    vector_t directed[10];
    result_t zero_res;

    initial begin
        zero_res = '0;
        //                     a      b     cin    s      c        cout  bcd    err
        directed[0] = '{4'd4,  4'd3,  1'b0, '{4'h7, 4'b0000, 1'b0, 4'h7, 1'b0}};
        directed[1] = '{4'd5,  4'd5,  1'b0, '{4'hA, 4'b0101, 1'b1, 4'h0, 1'b0}};
        directed[2] = '{4'd9,  4'd9,  1'b1, '{4'h3, 4'b1001, 1'b1, 4'h9, 1'b0}};
        directed[3] = '{4'd15, 4'd15, 1'b1, '{4'hF, 4'b1111, 1'b1, 4'h5, 1'b1}};
        directed[4] = '{4'd0,  4'd0,  1'b0, '{4'h0, 4'b0000, 1'b0, 4'h0, 1'b0}};
        directed[5] = '{4'd0,  4'd9,  1'b0, '{4'h9, 4'b0000, 1'b0, 4'h9, 1'b0}};
        directed[6] = '{4'd1,  4'd9,  1'b0, '{4'hA, 4'b0001, 1'b1, 4'h0, 1'b0}};
        directed[7] = '{4'd8,  4'd1,  1'b0, '{4'h9, 4'b0000, 1'b0, 4'h9, 1'b0}};
        directed[8] = '{4'd7,  4'd8,  1'b1, '{4'h0, 4'b1111, 1'b1, 4'h6, 1'b0}};
        directed[9] = '{4'd10, 4'd0,  1'b0, '{4'hA, 4'b0000, 1'b1, 4'h0, 1'b1}};

        a     = 4'd0;
        b     = 4'd0;
        cin   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_state", zero_res);
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_held", zero_res);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        foreach (directed[i]) begin
            applyStimulus(directed[i].a, directed[i].b, directed[i].cin, directed[i].exp);
        end

        // Mid-operation reset: the 9+9 in flight must be discarded and outputs cleared asynchronously.
        @(negedge clk);
        a   = 4'd9;
        b   = 4'd9;
        cin = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", zero_res);
        @(posedge clk);
        #1 checkOutput("reset_discard", zero_res);

        // Release between edges; the very next edge must carry 9+9=18 -> bcd 8, cout 1.
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{4'h2, 4'b1001, 1'b1, 4'h8, 1'b0});

        $display("[TB] full sweep");
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    applyStimulus(4'(ia), 4'(ib), 1'(ic), model(4'(ia), 4'(ib), 1'(ic)));
                end
            end
        end

        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
